// File: rtl/bram_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : bram_phase_seq
// Brief    : Single-port BRAM sequencer, frames of READ -> GAP1 -> WRITE -> GAP2.
//            Optional write-stall timeout: define BRAMSEQ_STALL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bram_phase_seq #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int RD_LAT    = 1,
    parameter int STALL_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [LEN_W-1:0]  i_rd_len,
    input  logic [LEN_W-1:0]  i_gap1_len,
    input  logic [LEN_W-1:0]  i_wr_len,
    input  logic [LEN_W-1:0]  i_gap2_len,
    input  logic [ADDR_W-1:0] i_rd_base,
    input  logic [ADDR_W-1:0] i_wr_base,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_bram_rdata,
    output logic              o_cs_rd,
    output logic              o_cs_wr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic [15:0]       o_frame_cnt,
    output logic              o_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_GAP1  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_GAP2  = 3'd4;

    logic [2:0]                  r_state;
    logic [LEN_W-1:0]            r_k;
    logic [3:0][LEN_W-1:0]       r_len;
    logic [ADDR_W-1:0]           r_rd_base;
    logic [ADDR_W-1:0]           r_wr_base;
    logic                        r_loop;
    logic                        r_stop_pend;
    logic                        r_cs_rd;
    logic                        r_cs_wr;
    logic                        r_we;
    logic [ADDR_W-1:0]           r_addr;
    logic [DATA_W-1:0]           r_wdata;
    logic [DATA_W-1:0]           r_rd_data;
    logic                        r_rd_valid;
    logic [15:0]                 r_frame_cnt;
    logic [RD_LAT-1:0]           r_tag;
    logic                        r_err;

    logic [3:0][LEN_W-1:0]       w_in_len;
    logic [2:0]                  w_start_phase;
    logic [2:0]                  w_next_in_frame;
    logic [2:0]                  w_restart_phase;
    logic [LEN_W-1:0]            w_cur_len;
    logic                        w_last;
    logic                        w_beat;
    logic                        w_stop_now;
    logic [ADDR_W-1:0]           w_k_addr;
    logic [ADDR_W-1:0]           w_rd_addr;
    logic [ADDR_W-1:0]           w_wr_addr;

    // Lowest-numbered phase state at or after from_st whose length is nonzero;
    // c_IDLE when none remains, which marks the end of the frame.
    function automatic logic [2:0] f_first_phase(input logic [2:0] from_st,
                                                 input logic [3:0][LEN_W-1:0] lens);
        logic [2:0] res;
        res = c_IDLE;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i + 1) >= from_st) && (lens[i] != '0)) begin
                res = 3'(i + 1);
            end
        end
        return res;
    endfunction

    assign w_in_len        = {i_gap2_len, i_wr_len, i_gap1_len, i_rd_len};
    assign w_start_phase   = f_first_phase(c_READ, w_in_len);
    assign w_next_in_frame = f_first_phase(r_state + 3'd1, r_len);
    assign w_restart_phase = f_first_phase(c_READ, r_len);

    always_comb begin
        w_cur_len = '0;
        case (r_state)
            c_READ:  w_cur_len = r_len[0];
            c_GAP1:  w_cur_len = r_len[1];
            c_WRITE: w_cur_len = r_len[2];
            c_GAP2:  w_cur_len = r_len[3];
            default: w_cur_len = '0;
        endcase
    end

    assign w_last     = (r_k == w_cur_len - 1'b1);
    assign w_beat     = (r_state == c_WRITE) ? i_wr_valid : (r_state != c_IDLE);
    assign w_stop_now = r_stop_pend | i_stop;

    generate
        if (LEN_W >= ADDR_W) begin : g_k_trunc
            assign w_k_addr = r_k[ADDR_W-1:0];
        end else begin : g_k_ext
            assign w_k_addr = {{(ADDR_W-LEN_W){1'b0}}, r_k};
        end
    endgenerate

    assign w_rd_addr = r_rd_base + w_k_addr;
    assign w_wr_addr = r_wr_base + w_k_addr;

    // Read tags ride alongside the registered chip select so tag and address line up.
    generate
        if (RD_LAT == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= r_cs_rd;
            end
        end else begin : g_tag_multi
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= {r_tag[RD_LAT-2:0], r_cs_rd};
            end
        end
    endgenerate

`ifdef BRAMSEQ_STALL_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(STALL_MAX + 1);
    logic [c_STALL_W-1:0] r_stall;
    logic                 w_stall_hit;
    assign w_stall_hit = (r_state == c_WRITE) && !i_wr_valid &&
                         (r_stall == c_STALL_W'(STALL_MAX - 1));
    always_ff @(posedge clk) begin
        if (rst || r_state != c_WRITE || i_wr_valid || w_stall_hit) r_stall <= '0;
        else                                                        r_stall <= r_stall + 1'b1;
    end
`else
    logic w_stall_hit;
    assign w_stall_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_k         <= '0;
            r_len       <= '0;
            r_rd_base   <= '0;
            r_wr_base   <= '0;
            r_loop      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_cs_rd     <= 1'b0;
            r_cs_wr     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cs_rd    <= 1'b0;
            r_cs_wr    <= 1'b0;
            r_we       <= 1'b0;
            r_rd_valid <= r_tag[RD_LAT-1];
            if (r_tag[RD_LAT-1]) r_rd_data <= i_bram_rdata;

            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_len       <= w_in_len;
                        r_rd_base   <= i_rd_base;
                        r_wr_base   <= i_wr_base;
                        r_loop      <= i_loop;
                        r_stop_pend <= 1'b0;
                        r_err       <= 1'b0;
                        r_k         <= '0;
                        r_state     <= w_start_phase;
                        // An empty frame completes immediately.
                        r_frame_cnt <= (w_start_phase == c_IDLE) ? 16'd1 : 16'd0;
                    end
                end
                c_READ, c_GAP1, c_WRITE, c_GAP2: begin
                    if (i_stop) r_stop_pend <= 1'b1;
                    if (r_state == c_READ) begin
                        r_cs_rd <= 1'b1;
                        r_addr  <= w_rd_addr;
                    end
                    if (r_state == c_WRITE) begin
                        r_cs_wr <= !w_stall_hit;
                        if (i_wr_valid) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_wr_addr;
                            r_wdata <= i_wr_data;
                        end
                    end
                    if (w_stall_hit) begin
                        r_err       <= 1'b1;
                        r_state     <= c_IDLE;
                        r_stop_pend <= 1'b0;
                        r_k         <= '0;
                    end else if (w_beat) begin
                        if (w_last) begin
                            r_k <= '0;
                            if (w_next_in_frame != c_IDLE) begin
                                r_state <= w_next_in_frame;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                                if (r_loop && !w_stop_now) begin
                                    r_state <= w_restart_phase;
                                end else begin
                                    r_state     <= c_IDLE;
                                    r_stop_pend <= 1'b0;
                                end
                            end
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_wr_ready  = (r_state == c_WRITE) && i_wr_valid;
    assign o_cs_rd     = r_cs_rd;
    assign o_cs_wr     = r_cs_wr;
    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_busy      = (r_state != c_IDLE);
    assign o_frame_cnt = r_frame_cnt;
`ifdef BRAMSEQ_STALL_TIMEOUT_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/bram_phase_seq.md
Name: bram_phase_seq

Overview:
- Parametrised BRAM access sequencer. Repeats frames of READ -> GAP1 -> WRITE -> GAP2 against one single-port BRAM.
- Drives chip selects, address, write enable and write data.
- Phase lengths and base addresses are set per run. Runs once or in continuous loop mode.
- Sits between the frame controller and the BRAM primitive. Replaces the fixed-count read/idle/write/idle cycler.

Parameters:
- ADDR_W, 10, BRAM address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, BRAM data width
- LEN_W, 16, width of phase-length inputs
- RD_LAT, 1, BRAM read latency in cycles (>=1)
- STALL_MAX, 64, write-stall timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; accepted only in IDLE
- i_stop  in  1  one-cycle pulse; graceful stop at the end of the current frame
- i_loop  in  1  latched at start; 1 = continuous frames
- i_rd_len, i_gap1_len, i_wr_len, i_gap2_len  in  LEN_W each  phase lengths, latched at start
- i_rd_base, i_wr_base  in  ADDR_W each  phase base addresses, latched at start
- i_wr_data  in  DATA_W  write data source
- i_wr_valid  in  1  write data available
- o_wr_ready  out  1  write word consumed this cycle
- i_bram_rdata  in  DATA_W  BRAM read data
- o_cs_rd  out  1  read chip select
- o_cs_wr  out  1  write chip select
- o_we  out  1  BRAM write enable
- o_addr  out  ADDR_W  BRAM address
- o_wdata  out  DATA_W  BRAM write data
- o_rd_data  out  DATA_W  captured read data
- o_rd_valid  out  1  o_rd_data valid (one-cycle pulse per word)
- o_busy  out  1  not in IDLE
- o_frame_cnt  out  16  completed frames since start; wraps at 16 bits
- o_err  out  1  sticky stall-timeout flag

Behaviour:
- Reset: state IDLE, all outputs 0, read-tag pipeline flushed.
- Reset mid-operation:
  - Aborts immediately.
  - No further o_we.
  - In-flight read tags are discarded, so no o_rd_valid after reset.
- All BRAM-side outputs are registered. A phase's first address appears on o_addr the cycle after entry into that phase.
- States: IDLE, READ, GAP1, WRITE, GAP2.
- IDLE:
  - i_start=1 latches lengths, bases and i_loop.
  - Clears o_frame_cnt, o_err and any pending stop.
  - Goes to the first phase with nonzero length, in order READ, GAP1, WRITE, GAP2.
  - If all lengths are 0: stays IDLE, o_frame_cnt=1.
- Each phase has its own counter k, starting at 0. The phase ends after length beats. Zero-length phases are skipped in the same transition.
- READ:
  - Each cycle: o_cs_rd=1, o_addr=rd_base+k, k++.
  - A tag pipeline of depth RD_LAT marks each issued read.
  - When a tag emerges, i_bram_rdata is registered into o_rd_data and o_rd_valid=1.
  - Address-to-o_rd_valid latency = RD_LAT+1 cycles.
  - Tags complete even after leaving READ.
- GAP1/GAP2: o_cs_rd=o_cs_wr=o_we=0. Counts length cycles.
- WRITE:
  - o_cs_wr=1 for the whole phase.
  - Beat when i_wr_valid=1: o_we=1, o_addr=wr_base+k, o_wdata=i_wr_data, o_wr_ready=1 (combinational, same cycle), k++.
  - i_wr_valid=0: o_we=0, o_wr_ready=0, k held (stall).
- End of GAP2 (or of the last nonzero phase):
  - o_frame_cnt++.
  - If loop=1 and no stop pending: restart the frame at k=0 with the same bases. Otherwise go to IDLE.
- i_stop:
  - Sets the stop-pending flag. Honoured only at the frame boundary; never truncates a phase.
  - i_stop in IDLE is ignored.
  - i_stop and i_start together in IDLE: start wins, stop is discarded.
- i_start while busy: ignored.
- Address arithmetic: base+k, truncated to ADDR_W (wraps to 0).
- o_busy=1 in every state except IDLE.

Optional Feature:
- Macro BRAMSEQ_STALL_TIMEOUT_EN.
- Defined:
  - In WRITE, a counter tracks consecutive cycles with i_wr_valid=0.
  - On reaching STALL_MAX: o_err=1 (sticky until next accepted start), state goes to IDLE at once, o_frame_cnt is not incremented.
  - The counter clears on any beat.
- Undefined: stalls are unbounded; o_err is tied to 0.

Test Plan:
- Reset then start with rd/gap1/wr/gap2 lengths 4/2/4/2, rd_base=0x010, wr_base=0x020, loop=0, i_wr_valid=1 -> o_cs_rd for 4 cycles at addr 0x010-0x013; 4 o_rd_valid pulses, each RD_LAT+1 after its address; 4 writes at 0x020-0x023; o_frame_cnt=1; o_busy=0 after 12 active cycles.
- Lengths 3/0/3/0, wr_base=0x3FE, ADDR_W=10 -> write addresses 0x3FE, 0x3FF, 0x000; GAP phases skipped.
- Write phase with i_wr_valid toggling 1,0,0,1,1 over lengths 0/0/3/0 -> o_we on cycles 1,4,5 only; o_cs_wr held for 5 cycles; o_wr_ready matches o_we.
- loop=1, lengths 2/1/2/1, i_stop pulsed mid-WRITE of frame 3 -> frame 3 completes; o_frame_cnt=3; then IDLE; no partial frame.
- rst asserted during READ with RD_LAT=2 -> outputs 0 next cycle; no o_rd_valid afterwards; a fresh start is accepted.
- With BRAMSEQ_STALL_TIMEOUT_EN, STALL_MAX=8, i_wr_valid held 0 in WRITE -> o_err=1 after 8 stall cycles; IDLE; o_frame_cnt unchanged; next i_start clears o_err.
